// File: rtl/toggle_decoder.sv
// toggle_decoder: recovers LSB-first bytes from a T-flip-flop toggle-encoded line
// with idle-gap start detection, a one-deep output register and a saturating toggle counter.
module toggle_decoder #(
  parameter int IDLE_BITS = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic        Q,
  input  logic        Ready,
  output logic [7:0]  Data,
  output logic        Valid,
  output logic        Overrun,
  output logic        Busy,
  output logic [15:0] Toggles
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [3:0] IDLE_MAX = 4'(IDLE_BITS);
  logic [0:0]  state_q, state_d;
  logic        q_prev_q, q_prev_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic [15:0] tog_q, tog_d;
  logic        t_rec, in_shift, start, done, load;
  assign t_rec    = Q ^ q_prev_q;
  assign in_shift = state_q == SHIFT;
  assign start    = En && !in_shift && t_rec && idle_cnt_q == IDLE_MAX;
  assign done     = En && in_shift && bit_cnt_q == 3'd7;
  // A pending byte may be replaced only when it is being accepted on this same edge
  assign load     = done && (!valid_q || Ready);
  always_comb begin
    q_prev_d   = En ? Q : q_prev_q;
    state_d    = start ? SHIFT : done ? IDLE : state_q;
    idle_cnt_d = !En ? idle_cnt_q
               : (in_shift || t_rec) ? 4'd0
               : (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 4'd1;
    bit_cnt_d  = start ? 3'd0 : (En && in_shift) ? bit_cnt_q + 3'd1 : bit_cnt_q;
    shift_d    = (En && in_shift) ? {t_rec, shift_q[6:1]} : shift_q;
    data_d     = load ? {t_rec, shift_q} : data_q;
    valid_d    = load || (valid_q && !Ready);
    ovr_d      = ovr_q || (done && valid_q && !Ready);
    tog_d      = (En && t_rec && tog_q != 16'hFFFF) ? tog_q + 16'd1 : tog_q;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      q_prev_q   <= 1'b0;
      idle_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      tog_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      q_prev_q   <= q_prev_d;
      idle_cnt_q <= idle_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      tog_q      <= tog_d;
    end
  end
  assign Data    = data_q;
  assign Valid   = valid_q;
  assign Overrun = ovr_q;
  assign Busy    = in_shift;
  assign Toggles = tog_q;
endmodule
